// File: rtl/load_store_unit.sv
// load_store_unit: sequences CPU load/store requests onto the 128-byte
// big-endian data memory's 16-bit word port. Byte stores are done as a
// read-modify-write of the aligned word. Optional byte access support is
// controlled by the LSU_BYTE_ACCESS_EN macro; without it, any byte request
// returns an error and the memory is not touched.
module load_store_unit #(
  parameter int ADDR_WIDTH = 16,
  parameter int MEM_BYTES  = 128
) (
  input  logic                  Clock,
  input  logic                  ResetN,
  input  logic                  ReqValid,
  output logic                  ReqReady,
  input  logic                  ReqWrite,
  input  logic                  ReqByte,
  input  logic [ADDR_WIDTH-1:0] ReqAddress,
  input  logic [15:0]           ReqWriteData,
  output logic                  RespValid,
  output logic [15:0]           RespReadData,
  output logic                  RespError,
  output logic [ADDR_WIDTH-1:0] MemAddress,
  output logic [15:0]           MemWriteData,
  output logic                  MemWrite,
  output logic                  MemRead,
  input  logic [15:0]           MemReadData
);

  typedef enum logic [1:0] {IDLE, ACCESS, MERGE, RESP} state_t;

  localparam logic [ADDR_WIDTH-1:0] WordLimit = ADDR_WIDTH'(MEM_BYTES - 2);
  localparam logic [ADDR_WIDTH-1:0] ByteLimit = ADDR_WIDTH'(MEM_BYTES - 1);

  state_t      state;
  logic        reqWrite;
  logic        reqError;
  logic [15:0] loadData;   // response data staged until the RESP exit edge
  logic        reqLegal;

`ifdef LSU_BYTE_ACCESS_EN
  logic        reqByte;
  logic        reqLsb;      // selects the low byte of the big-endian word
  logic [7:0]  reqByteData;

  assign reqLegal = ReqByte ? (ReqAddress <= ByteLimit) : (ReqAddress <= WordLimit);
`else
  assign reqLegal = !ReqByte && (ReqAddress <= WordLimit);
`endif

  // Sequencer: every output is registered and set on the edge entering the
  // state in which it must be seen, so the response strobe lands on the edge
  // leaving RESP and ReqReady returns together with it.
  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) begin
      state        <= IDLE;
      ReqReady     <= 1'b0;
      RespValid    <= 1'b0;
      RespReadData <= '0;
      RespError    <= 1'b0;
      MemAddress   <= '0;
      MemWriteData <= '0;
      MemWrite     <= 1'b0;
      MemRead      <= 1'b0;
      reqWrite     <= 1'b0;
      reqError     <= 1'b0;
      loadData     <= '0;
`ifdef LSU_BYTE_ACCESS_EN
      reqByte      <= 1'b0;
      reqLsb       <= 1'b0;
      reqByteData  <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          RespValid <= 1'b0;
          if (ReqValid && ReqReady) begin
            ReqReady     <= 1'b0;
            reqWrite     <= ReqWrite;
            reqError     <= !reqLegal;
            MemWriteData <= ReqWriteData;
            // Byte requests (legal only when byte support is built) read first.
            MemRead      <= reqLegal && (!ReqWrite || ReqByte);
            MemWrite     <= reqLegal && ReqWrite && !ReqByte;
`ifdef LSU_BYTE_ACCESS_EN
            reqByte      <= ReqByte;
            reqLsb       <= ReqAddress[0];
            reqByteData  <= ReqWriteData[7:0];
            MemAddress   <= ReqByte ? {ReqAddress[ADDR_WIDTH-1:1], 1'b0} : ReqAddress;
`else
            MemAddress   <= ReqAddress;
`endif
            state        <= ACCESS;
          end else begin
            ReqReady <= 1'b1;
          end
        end

        ACCESS: begin
          MemRead  <= 1'b0;
          MemWrite <= 1'b0;
          state    <= RESP;
`ifdef LSU_BYTE_ACCESS_EN
          if (reqError || (reqWrite && !reqByte)) begin
            loadData <= '0;
          end else if (!reqByte) begin
            loadData <= MemReadData;
          end else if (!reqWrite) begin
            loadData <= {8'h00, reqLsb ? MemReadData[7:0] : MemReadData[15:8]};
          end else begin
            // Merge the store byte into the word just read and write it back.
            loadData     <= '0;
            MemWrite     <= 1'b1;
            MemWriteData <= reqLsb ? {MemReadData[15:8], reqByteData}
                                   : {reqByteData, MemReadData[7:0]};
            state        <= MERGE;
          end
`else
          loadData <= (reqError || reqWrite) ? 16'h0000 : MemReadData;
`endif
        end

`ifdef LSU_BYTE_ACCESS_EN
        MERGE: begin
          MemWrite <= 1'b0;
          state    <= RESP;
        end
`endif

        RESP: begin
          RespValid    <= 1'b1;
          RespError    <= reqError;
          RespReadData <= loadData;
          ReqReady     <= 1'b1;
          state        <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: byte-array reference model plus a fixture
// memory; directed scenarios then random traffic. Honors LSU_BYTE_ACCESS_EN.
module tb_load_store_unit;

`ifdef LSU_BYTE_ACCESS_EN
  localparam bit BYTE_EN = 1'b1;
`else
  localparam bit BYTE_EN = 1'b0;
`endif

  logic        Clock = 1'b0;
  logic        ResetN = 1'b1;
  logic        ReqValid = 1'b0;
  logic        ReqReady;
  logic        ReqWrite = 1'b0;
  logic        ReqByte = 1'b0;
  logic [15:0] ReqAddress = '0;
  logic [15:0] ReqWriteData = '0;
  logic        RespValid;
  logic [15:0] RespReadData;
  logic        RespError;
  logic [15:0] MemAddress;
  logic [15:0] MemWriteData;
  logic        MemWrite;
  logic        MemRead;
  logic [15:0] MemReadData;

  load_store_unit #(.ADDR_WIDTH(16), .MEM_BYTES(128)) dut (
    .Clock(Clock), .ResetN(ResetN),
    .ReqValid(ReqValid), .ReqReady(ReqReady), .ReqWrite(ReqWrite), .ReqByte(ReqByte),
    .ReqAddress(ReqAddress), .ReqWriteData(ReqWriteData),
    .RespValid(RespValid), .RespReadData(RespReadData), .RespError(RespError),
    .MemAddress(MemAddress), .MemWriteData(MemWriteData),
    .MemWrite(MemWrite), .MemRead(MemRead), .MemReadData(MemReadData)
  );

  always #5 Clock = ~Clock;

  // Fixture data memory: big-endian, combinational read, write at clock edge.
  logic [7:0] mem [0:127];
  logic       initDone = 1'b0;
  logic [6:0] ma0, ma1;
  assign ma0 = MemAddress[6:0];
  assign ma1 = ma0 + 7'd1;
  assign MemReadData = {mem[ma0], mem[ma1]};

  always @(posedge Clock) begin
    if (!initDone) begin
      for (int i = 0; i < 128; i++) mem[i] <= 8'(i * 37 + 5);
      initDone <= 1'b1;
    end else if (MemWrite) begin
      mem[ma0] <= MemWriteData[15:8];
      mem[ma1] <= MemWriteData[7:0];
    end
  end

  // Strobe monitor: cumulative counts, sampled mid-cycle.
  int          rdCnt = 0, wrCnt = 0, bothCnt = 0, respCnt = 0;
  logic [15:0] lastWrAddr = '0, lastWrData = '0, lastRdAddr = '0;
  always @(negedge Clock) begin
    if (MemRead) begin rdCnt <= rdCnt + 1; lastRdAddr <= MemAddress; end
    if (MemWrite) begin wrCnt <= wrCnt + 1; lastWrAddr <= MemAddress; lastWrData <= MemWriteData; end
    if (MemRead && MemWrite) bothCnt <= bothCnt + 1;
    if (RespValid) respCnt <= respCnt + 1;
  end

  // Reference model state: plain byte array.
  logic [7:0] refMem [0:127];
  int nCmp = 0, nBad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nCmp++;
    if (got !== exp) begin
      nBad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Drive one request until accepted; returns after the accept edge.
  task automatic issue(input logic w, input logic b, input logic [15:0] a, input logic [15:0] d);
    int n;
    @(negedge Clock);
    ReqValid = 1'b1; ReqWrite = w; ReqByte = b; ReqAddress = a; ReqWriteData = d;
    n = 0;
    while (!ReqReady && n < 20) begin @(negedge Clock); n++; end
    if (n >= 20) chk("accept_timeout", 32'(n), 32'd0);
    @(posedge Clock); #1;
    ReqValid = 1'b0;
  endtask

  task automatic doReq(input logic w, input logic b, input logic [15:0] a, input logic [15:0] d);
    logic        err;
    logic [15:0] expData, expWrData, expAddr;
    logic [6:0]  i, al;
    int          expRd, expWr, expLat, rd0, wr0, lat;
    err = b ? (a > 16'd127) : (a > 16'd126);
    if (b && !BYTE_EN) err = 1'b1;
    expData = '0; expWrData = '0; expRd = 0; expWr = 0; expLat = 2;
    expAddr = b ? (a & 16'hFFFE) : a;
    i = a[6:0];
    al = {i[6:1], 1'b0};
    if (!err) begin
      if (!b && w) begin
        refMem[i] = d[15:8]; refMem[i + 7'd1] = d[7:0];
        expWr = 1; expWrData = d;
      end else if (!b) begin
        expData = {refMem[i], refMem[i + 7'd1]}; expRd = 1;
      end else if (!w) begin
        expData = {8'h00, refMem[i]}; expRd = 1;
      end else begin
        refMem[i] = d[7:0];
        expRd = 1; expWr = 1; expLat = 3;
        expWrData = {refMem[al], refMem[al + 7'd1]};
      end
    end
    rd0 = rdCnt; wr0 = wrCnt;
    issue(w, b, a, d);
    lat = 0;
    while (!RespValid && lat < 10) begin @(posedge Clock); #1; lat++; end
    chk("latency", 32'(lat), 32'(expLat));
    chk("resp_error", 32'(RespError), 32'(err));
    if (!w || err) chk("resp_data", 32'(RespReadData), 32'(expData));
    chk("read_strobes", 32'(rdCnt - rd0), 32'(expRd));
    chk("write_strobes", 32'(wrCnt - wr0), 32'(expWr));
    if (expRd != 0) chk("read_addr", 32'(lastRdAddr), 32'(expAddr));
    if (expWr != 0) begin
      chk("write_addr", 32'(lastWrAddr), 32'(expAddr));
      chk("write_data", 32'(lastWrData), 32'(expWrData));
    end
    @(posedge Clock); #1;
    chk("resp_pulse", 32'(RespValid), 32'd0);
  endtask

  initial begin
    int n, r0;
    logic [15:0] a;
    for (int i = 0; i < 128; i++) refMem[i] = 8'(i * 37 + 5);

    // Reset state, asserted asynchronously before any clock edge.
    #2 ResetN = 1'b0;
    #2;
    chk("rst_ready", 32'(ReqReady), 32'd0);
    chk("rst_respvalid", 32'(RespValid), 32'd0);
    chk("rst_resperror", 32'(RespError), 32'd0);
    chk("rst_respdata", 32'(RespReadData), 32'd0);
    chk("rst_memaddr", 32'(MemAddress), 32'd0);
    chk("rst_memwdata", 32'(MemWriteData), 32'd0);
    chk("rst_strobes", 32'({MemRead, MemWrite}), 32'd0);
    repeat (3) @(negedge Clock);
    ResetN = 1'b1;
    @(posedge Clock); #1;
    chk("ready_after_reset", 32'(ReqReady), 32'd1);

    // Directed scenarios.
    doReq(1'b1, 1'b0, 16'd2, 16'h1234);
    doReq(1'b0, 1'b0, 16'd2, 16'h0000);
    doReq(1'b1, 1'b1, 16'd3, 16'h00AB);
    doReq(1'b0, 1'b1, 16'd2, 16'h0000);
    doReq(1'b0, 1'b1, 16'd3, 16'h0000);
    doReq(1'b0, 1'b0, 16'd2, 16'h0000);
    doReq(1'b1, 1'b0, 16'd127, 16'hBEEF);
    doReq(1'b0, 1'b1, 16'd128, 16'h0000);
    doReq(1'b0, 1'b0, 16'd126, 16'h0000);
    doReq(1'b0, 1'b1, 16'd127, 16'h0000);
    doReq(1'b0, 1'b1, 16'd0, 16'h0000);
    doReq(1'b0, 1'b0, 16'd0, 16'h0000);
    doReq(1'b0, 1'b0, 16'hFFFF, 16'h0000);

    // Reset in the write cycle of a store: the write must not land.
    issue(1'b1, BYTE_EN, 16'd10, 16'h5A5A);
    n = 0;
    while (!MemWrite && n < 10) begin @(negedge Clock); n++; end
    chk("store_reaches_write", 32'(MemWrite), 32'd1);
    r0 = respCnt;
    #2 ResetN = 1'b0;
    #1;
    chk("abort_memwrite", 32'(MemWrite), 32'd0);
    chk("abort_ready", 32'(ReqReady), 32'd0);
    repeat (2) @(negedge Clock);
    ResetN = 1'b1;
    @(posedge Clock); #1;
    chk("abort_ready_after", 32'(ReqReady), 32'd1);
    repeat (3) @(posedge Clock);
    #1;
    chk("abort_no_resp", 32'(respCnt - r0), 32'd0);
    chk("abort_mem_unchanged", 32'({mem[10], mem[11]}), 32'({refMem[10], refMem[11]}));
    doReq(1'b0, 1'b0, 16'd10, 16'h0000);

    // Random traffic, biased around the top of the address range.
    for (int t = 0; t < 150; t++) begin
      if ($urandom_range(0, 7) == 0) a = 16'($urandom);
      else a = 16'($urandom_range(0, 129));
      doReq(1'($urandom), 1'($urandom), a, 16'($urandom));
    end

    chk("never_both_strobes", 32'(bothCnt), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
    $finish;
  end

endmodule
